// File: rtl/pin_entry_collector.sv
// Keypad PIN collector: gathers four BCD digits and presents the assembled code
// with a fixed-length acknowledge pulse on ENTER. Aborts on clear, disable or timeout.
module pin_entry_collector #(
    parameter int unsigned ACK_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pin_enable,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_enter,
    input  logic        key_clear,
    output logic [15:0] code,
    output logic        code_ack,
    output logic [2:0]  digit_count,
    output logic        entry_error,
    output logic        entry_timeout
);

    typedef enum logic [1:0] {IDLE, COLLECT, READY, ACK} state_t;

    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  ACK_LAST = 4'(ACK_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] code_nx;
    logic        code_ack_nx;
    logic [2:0]  digit_count_nx;
    logic        entry_error_nx, entry_timeout_nx;
    logic [15:0] tmr, tmr_nx;
    logic [3:0]  ack_cnt, ack_cnt_nx;
    logic        digit_ok;

    assign digit_ok = (key_digit <= 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            code          <= '0;
            code_ack      <= 1'b0;
            digit_count   <= '0;
            entry_error   <= 1'b0;
            entry_timeout <= 1'b0;
            tmr           <= '0;
            ack_cnt       <= '0;
        end else begin
            state         <= state_nx;
            code          <= code_nx;
            code_ack      <= code_ack_nx;
            digit_count   <= digit_count_nx;
            entry_error   <= entry_error_nx;
            entry_timeout <= entry_timeout_nx;
            tmr           <= tmr_nx;
            ack_cnt       <= ack_cnt_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        code_nx          = code;
        code_ack_nx      = code_ack;
        digit_count_nx   = digit_count;
        entry_error_nx   = 1'b0;
        entry_timeout_nx = 1'b0;
        tmr_nx           = '0;
        ack_cnt_nx       = ack_cnt;

        unique case (state)
            IDLE: begin
                if (pin_enable && !key_clear) begin
                    if (key_enter) begin
                        entry_error_nx = 1'b1;
                    end else if (key_valid) begin
                        if (digit_ok) begin
                            code_nx        = {12'h000, key_digit};
                            digit_count_nx = 3'd1;
                            state_nx       = COLLECT;
                        end else begin
                            entry_error_nx = 1'b1;
                        end
                    end
                end
            end

            // Any strobe leaves tmr_nx at its zero default, restarting the idle window.
            COLLECT, READY: begin
                if (!pin_enable || key_clear) begin
                    digit_count_nx = '0;
                    state_nx       = IDLE;
                end else if (key_enter) begin
                    if (state == READY) begin
                        code_ack_nx = 1'b1;
                        ack_cnt_nx  = '0;
                        state_nx    = ACK;
                    end else begin
                        entry_error_nx = 1'b1;
                        digit_count_nx = '0;
                        state_nx       = IDLE;
                    end
                end else if (key_valid) begin
                    if (state == COLLECT && digit_ok) begin
                        code_nx        = {code[11:0], key_digit};
                        digit_count_nx = digit_count + 3'd1;
                        if (digit_count == 3'd3)
                            state_nx = READY;
                    end else begin
                        entry_error_nx = 1'b1;
                    end
                end else if (tmr == TMR_LAST) begin
                    entry_timeout_nx = 1'b1;
                    digit_count_nx   = '0;
                    state_nx         = IDLE;
                end else begin
                    tmr_nx = tmr + 16'd1;
                end
            end

            ACK: begin
                if (ack_cnt == ACK_LAST) begin
                    code_ack_nx    = 1'b0;
                    digit_count_nx = '0;
                    state_nx       = IDLE;
                end else begin
                    ack_cnt_nx = ack_cnt + 4'd1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed bench for pin_entry_collector: each step queues the expected post-edge
// outputs, which are popped and checked with immediate assertions after the edge.
module tb_pin_entry_collector;

    logic        clk;
    logic        rst;
    logic        pin_enable;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_enter;
    logic        key_clear;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        entry_timeout;

    typedef struct packed {
        logic [15:0] code;
        logic        ack;
        logic [2:0]  cnt;
        logic        err;
        logic        to;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    pin_entry_collector #(
        .ACK_CYCLES    (4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pin_enable   (pin_enable),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .key_enter    (key_enter),
        .key_clear    (key_clear),
        .code         (code),
        .code_ack     (code_ack),
        .digit_count  (digit_count),
        .entry_error  (entry_error),
        .entry_timeout(entry_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_front();
        exp_t  x;
        string t;
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".code"},    code,                   x.code);
        chk({t, ".ack"},     {15'd0, code_ack},      {15'd0, x.ack});
        chk({t, ".count"},   {13'd0, digit_count},   {13'd0, x.cnt});
        chk({t, ".error"},   {15'd0, entry_error},   {15'd0, x.err});
        chk({t, ".timeout"}, {15'd0, entry_timeout}, {15'd0, x.to});
    endtask

    // Drive one cycle of strobes, queue expected outputs after the edge, then check.
    task automatic step(input logic v, input logic [3:0] d, input logic e, input logic c,
                        input string tag, input logic [15:0] ec, input logic ea,
                        input logic [2:0] en, input logic ee, input logic et);
        exp_t x;
        key_valid = v;
        key_digit = d;
        key_enter = e;
        key_clear = c;
        x.code = ec; x.ack = ea; x.cnt = en; x.err = ee; x.to = et;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        check_front();
    endtask

    initial begin
        rst        = 1'b1;
        pin_enable = 1'b0;
        key_valid  = 1'b0;
        key_digit  = 4'd0;
        key_enter  = 1'b0;
        key_clear  = 1'b0;

        step(0, 0, 0, 0, "reset", 16'h0000, 0, 0, 0, 0);
        rst = 1'b0;
        pin_enable = 1'b1;

        // 5,9,9,0 + ENTER with rejected A and fifth digit in READY
        step(1, 4'd5, 0, 0, "d5",   16'h0005, 0, 1, 0, 0);
        step(1, 4'd9, 0, 0, "d9a",  16'h0059, 0, 2, 0, 0);
        step(1, 4'd9, 0, 0, "d9b",  16'h0599, 0, 3, 0, 0);
        step(1, 4'd0, 0, 0, "d0",   16'h5990, 0, 4, 0, 0);
        step(1, 4'hA, 0, 0, "rdyA", 16'h5990, 0, 4, 1, 0);
        step(1, 4'd7, 0, 0, "rdy7", 16'h5990, 0, 4, 1, 0);
        step(0, 0,    0, 0, "rdyq", 16'h5990, 0, 4, 0, 0);
        step(0, 0,    1, 0, "ent1", 16'h5990, 1, 4, 0, 0);
        step(1, 4'd1, 1, 0, "ack2", 16'h5990, 1, 4, 0, 0);
        step(0, 0,    0, 0, "ack3", 16'h5990, 1, 4, 0, 0);
        step(0, 0,    0, 0, "ack4", 16'h5990, 1, 4, 0, 0);
        step(0, 0,    0, 0, "ackd", 16'h5990, 0, 0, 0, 0);

        // short ENTER, then a full 1,2,3,4 entry
        step(1, 4'd1, 0, 0, "s1",   16'h0001, 0, 1, 0, 0);
        step(1, 4'hB, 0, 0, "colB", 16'h0001, 0, 1, 1, 0);
        step(1, 4'd2, 0, 0, "s2",   16'h0012, 0, 2, 0, 0);
        step(0, 0,    1, 0, "sent", 16'h0012, 0, 0, 1, 0);
        step(0, 0,    0, 0, "sq",   16'h0012, 0, 0, 0, 0);
        step(1, 4'd1, 0, 0, "f1",   16'h0001, 0, 1, 0, 0);
        step(1, 4'd2, 0, 0, "f2",   16'h0012, 0, 2, 0, 0);
        step(1, 4'd3, 0, 0, "f3",   16'h0123, 0, 3, 0, 0);
        step(1, 4'd4, 0, 0, "f4",   16'h1234, 0, 4, 0, 0);
        step(0, 0,    1, 0, "fent", 16'h1234, 1, 4, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, "fack", 16'h1234, 1, 4, 0, 0);
        step(0, 0,    0, 0, "fdone", 16'h1234, 0, 0, 0, 0);

        // IDLE rejects: bad digit, bare ENTER
        step(1, 4'hF, 0, 0, "idleF", 16'h1234, 0, 0, 1, 0);
        step(0, 0,    1, 0, "idleE", 16'h1234, 0, 0, 1, 0);

        // timeout after 1000 idle cycles
        step(1, 4'd3, 0, 0, "t3a",  16'h0003, 0, 1, 0, 0);
        step(1, 4'd3, 0, 0, "t3b",  16'h0033, 0, 2, 0, 0);
        for (int i = 0; i < 999; i++)
            step(0, 0, 0, 0, "twait", 16'h0033, 0, 2, 0, 0);
        step(0, 0,    0, 0, "tfire", 16'h0033, 0, 0, 0, 1);
        step(0, 0,    0, 0, "tpost", 16'h0033, 0, 0, 0, 0);

        // clear+enter in READY
        step(1, 4'd1, 0, 0, "c1",   16'h0001, 0, 1, 0, 0);
        step(1, 4'd2, 0, 0, "c2",   16'h0012, 0, 2, 0, 0);
        step(1, 4'd3, 0, 0, "c3",   16'h0123, 0, 3, 0, 0);
        step(1, 4'd4, 0, 0, "c4",   16'h1234, 0, 4, 0, 0);
        step(0, 0,    1, 1, "clrent", 16'h1234, 0, 0, 0, 0);
        step(0, 0,    0, 0, "clrq", 16'h1234, 0, 0, 0, 0);

        // enter+valid in READY, then reset during ACK
        step(1, 4'd5, 0, 0, "e5",   16'h0005, 0, 1, 0, 0);
        step(1, 4'd6, 0, 0, "e6",   16'h0056, 0, 2, 0, 0);
        step(1, 4'd7, 0, 0, "e7",   16'h0567, 0, 3, 0, 0);
        step(1, 4'd8, 0, 0, "e8",   16'h5678, 0, 4, 0, 0);
        step(1, 4'd9, 1, 0, "entv", 16'h5678, 1, 4, 0, 0);
        step(0, 0,    0, 0, "eack2", 16'h5678, 1, 4, 0, 0);
        rst = 1'b1;
        step(0, 0,    0, 0, "rstack", 16'h0000, 0, 0, 0, 0);
        rst = 1'b0;

        // pin_enable drop mid-COLLECT
        step(1, 4'd4, 0, 0, "p4",   16'h0004, 0, 1, 0, 0);
        step(1, 4'd2, 0, 0, "p2",   16'h0042, 0, 2, 0, 0);
        pin_enable = 1'b0;
        step(0, 0,    0, 0, "pdrop", 16'h0042, 0, 0, 0, 0);
        step(1, 4'd7, 0, 0, "poffd", 16'h0042, 0, 0, 0, 0);
        step(0, 0,    1, 0, "poffe", 16'h0042, 0, 0, 0, 0);
        pin_enable = 1'b1;
        step(1, 4'd8, 0, 0, "pon8", 16'h0008, 0, 1, 0, 0);
        step(0, 0,    0, 1, "pclr", 16'h0008, 0, 0, 0, 0);
        step(0, 0,    0, 0, "pend", 16'h0008, 0, 0, 0, 0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard: observed %0d leftover expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_entry_collector.md
# pin_entry_collector

Upstream stage of the parking gate controller. Collects four BCD keypad digits, then presents the assembled 16-bit code with a fixed-length `code_ack` pulse on a keypad ENTER. Its `code`/`code_ack` outputs drive the controller's `code`/`code_ack` inputs. The block also aborts stale or malformed entries by timeout, clear and validity checks.

## Interface

- `ACK_CYCLES`, default 4: number of cycles `code_ack` is held high; legal range 1..15.
- `TIMEOUT_CYCLES`, default 1000: idle cycles with no accepted key before a partial entry is discarded; legal range 1..65535.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: one clock; reset is synchronous and active-high.
- `pin_enable`  in  1: entry permitted (controller waiting for a PIN); low discards any partial entry.
- `key_valid`  in  1: single-cycle strobe, `key_digit` valid.
- `key_digit`  in  4: BCD digit 0..9.
- `key_enter`  in  1: single-cycle ENTER strobe.
- `key_clear`  in  1: single-cycle CLEAR strobe.
- `code`  out  16: assembled PIN; first digit in [15:12], last digit in [3:0].
- `code_ack`  out  1: code valid; high for exactly `ACK_CYCLES` cycles.
- `digit_count`  out  3: digits held, 0..4.
- `entry_error`  out  1: one-cycle pulse on a rejected key or a short ENTER.
- `entry_timeout`  out  1: one-cycle pulse when a partial entry times out.

## Operation

- States: IDLE, COLLECT, READY, ACK. All outputs are registered.
- Reset values: state IDLE, `code`=0, `code_ack`=0, `digit_count`=0, `entry_error`=0, `entry_timeout`=0, timeout and ack counters 0.
- Strobe priority when several strobes arrive in the same cycle: `key_clear` > `key_enter` > `key_valid`.
- IDLE:
  - Valid digit with `pin_enable`=1: load `code`={12'h000, digit}, set `digit_count`=1, go to COLLECT.
  - ENTER: raises `entry_error`.
  - Strobes with `pin_enable`=0: ignored.
- COLLECT:
  - Valid digit: `code`={code[11:0], digit}, `digit_count`+1.
  - Reaching 4 digits moves to READY.
  - ENTER: raises `entry_error`, clears `digit_count`, returns to IDLE.
- READY:
  - ENTER: go to ACK.
  - Further digits: rejected with `entry_error`; `code` unchanged.
- Digit > 9 in any state: rejected with `entry_error`; no other effect.
- `key_clear` or `pin_enable`=0 in COLLECT or READY: `digit_count`=0, go to IDLE. No error pulse.
- Timeout:
  - The counter runs in COLLECT and READY and resets on every accepted or rejected strobe.
  - When it reaches `TIMEOUT_CYCLES`: pulse `entry_timeout`, set `digit_count`=0, go to IDLE.
- ACK:
  - `code_ack`=1 and `code` held stable.
  - All strobes and `pin_enable` are ignored.
  - After `ACK_CYCLES` cycles: `code_ack`=0, `digit_count`=0, go to IDLE.
- `code` keeps its last value in IDLE until the first digit of the next entry.

## Timing

- Strobes are sampled on the rising edge. The effect on `code`/`digit_count` is visible in the following cycle (1-cycle latency).
- ENTER accepted at edge N: `code_ack` is high for cycles N+1 .. N+`ACK_CYCLES`, and low at N+`ACK_CYCLES`+1.
- The next digit is accepted no earlier than edge N+`ACK_CYCLES`+1.
- `entry_error` and `entry_timeout` are exactly one cycle wide and never high together.
- Timeout fires `TIMEOUT_CYCLES` cycles after the last strobe edge.
- `rst` mid-entry or mid-ACK returns all outputs to their reset values on the next edge.

## Test plan

- Keys 5,9,9,0 then ENTER with `pin_enable`=1, `ACK_CYCLES`=4 -> `code`=16'h5990; `code_ack` high for 4 cycles starting the cycle after ENTER; `digit_count` goes 1,2,3,4, then 0 after the ack.
- Keys 1,2 then ENTER -> one-cycle `entry_error`, `digit_count`=0, no `code_ack`. Follow with 1,2,3,4 + ENTER -> `code`=16'h1234 acked.
- Digit 4'hA, then a fifth digit 7 after 5,9,9,0 -> `entry_error` on each; `code` stays 16'h5990.
- Keys 3,3 then 1000 idle cycles (`TIMEOUT_CYCLES`=1000) -> `entry_timeout` pulse on the 1000th cycle, `digit_count`=0.
- Same-cycle `key_clear`+`key_enter` in READY -> entry cleared, no ack, no error. `key_enter`+`key_valid` in READY -> ack only.
- `rst` during ACK (cycle 2 of 4) -> `code_ack`=0, `code`=0, `digit_count`=0 on the next edge. `pin_enable` dropping mid-COLLECT -> `digit_count`=0, strobes ignored while low.
